mem_stage_nb: RTL and testbench
===============================

// Module: mem_stage_nb
// PURPOSE
//  Non-blocking MEM pipeline stage. It sits between EX and WB and holds up to DEPTH in-flight instructions in an in-order queue.
//  Each instruction may have an outstanding data-SRAM request; responses (data_ok/rdata) return strictly in issue order.
//  It performs load extraction and sign/zero extension, forwards the youngest register write to ID, and drains stale responses after a flush.
// PARAMETERS
//  DEPTH     2   queue entries (power of 2, >=2); max instructions resident in MEM
//  DATA_W    32  data-SRAM / register data width (32 or 64)
//  PC_W      32  PC width
//  SIDE_W    64  opaque side-band (csr/tlb/exception fields), passed through unchanged
// PORTS
//  clk           in   1       clock
//  resetn        in   1       synchronous reset, active low
//  flush         in   1       kill all resident entries (exception/ertn/refetch)
//  ex_valid      in   1       EX presents an instruction
//  mem_allowin   out  1       queue can accept this cycle
//  ex_req        in   1       this instruction issued a data-SRAM request in EX
//  ex_ld         in   1       load: rf_wdata comes from rdata
//  ex_size       in   2       0=byte 1=half 2=word 3=dword(DATA_W=64 only)
//  ex_unsigned   in   1       zero-extend a sub-width load
//  ex_addr_lo    in   $clog2(DATA_W/8)  low address bits
//  ex_rf_we      in   1       writes register file
//  ex_rf_waddr   in   5       destination register
//  ex_result     in   DATA_W  ALU/counter result
//  ex_pc         in   PC_W    instruction PC
//  ex_side       in   SIDE_W  side-band
//  data_ok       in   1       one response beat for the oldest outstanding request
//  rdata         in   DATA_W  response data, valid with data_ok
//  wb_allowin    in   1       WB accepts
//  mem_to_wb_valid out 1      head entry is complete
//  wb_rf_we,wb_rf_waddr,wb_rf_wdata,wb_pc,wb_side  out  1/5/DATA_W/PC_W/SIDE_W  head entry fields
//  fwd_we        out  1       youngest valid entry writes the register file
//  fwd_waddr     out  5       its destination
//  fwd_wdata     out  DATA_W  its data (valid only if fwd_busy=0)
//  fwd_busy      out  1       youngest writer is a load without data yet; ID must stall
//  drain_cnt     out  $clog2(DEPTH+1)  stale responses still expected
// BEHAVIOUR
//  - Reset: queue empty, head/tail/count=0, drain_cnt=0; all valid/we/busy outputs 0, data outputs 0.
//  - Entry fields: valid, req, done, plus the captured EX fields. On enqueue, done = ~ex_req.
//  - mem_allowin = (count<DEPTH) | (mem_to_wb_valid & wb_allowin). Enqueue = ex_valid & mem_allowin & ~flush.
//  - Response routing: data_ok with drain_cnt>0 decrements drain_cnt and is discarded.
//    Otherwise it sets done and latches extracted data in the oldest entry having req & ~done.
//    data_ok with neither a stale nor a live request outstanding is an error (assertion).
//  - mem_to_wb_valid = head.valid & head.done; dequeue on mem_to_wb_valid & wb_allowin.
//    A head whose response arrives this cycle completes next cycle; there is no combinational rdata bypass to WB.
//  - Extraction: lane = addr_lo scaled by size; extend with ~unsigned & msb; word/dword passes through.
//    Non-load entries use ex_result.
//  - Forwarding: the youngest valid entry only. fwd_busy = fwd_we & ld & ~done.
//  - Flush (wins over enqueue and dequeue in the same cycle): all entries invalid, pointers reset.
//    drain_cnt += count of resident entries with req & ~done, excluding any such entry satisfied by data_ok this cycle.
//    Responses already latched are dropped.
//  - Simultaneous enqueue+dequeue when full: allowed; count unchanged.
//  - Pointers wrap modulo DEPTH.
//  - Reset mid-drain clears drain_cnt; the SRAM side is reset together with this block.
// STRUCTURE
//  - Shared package (pipe_pkg): ld size enum, DATA_W-generic load_extract function, entry struct typedef.
//  - One sub-module: mem_load_align (combinational rdata/addr_lo/size/unsigned -> DATA_W result), reused by WB if needed.
//  - Queue, response routing and drain counter stay in this module.
// TESTING
//  1. ld.b addr_lo=3, rdata=32'h80FF_0000, signed -> wb_rf_wdata=32'hFFFF_FF80; ld.hu addr_lo=2 -> 32'h0000_80FF.
//  2. Two loads back-to-back (DEPTH=2): mem_allowin deasserts with 2 resident.
//     data_ok 3 cycles later -> retire in order, PCs A then B.
//  3. Flush with 2 req entries pending: drain_cnt=2, next two data_ok are discarded.
//     A new load enqueued after the flush gets the third data_ok.
//  4. Flush in the same cycle as data_ok for the head: drain_cnt=1, not 2.
//  5. wb_allowin=0 for 5 cycles with head done -> outputs held stable, no loss; forward of the ALU op shows fwd_busy=0.
//  6. Load to r4 pending under an older ALU write to r4: fwd_waddr=4, fwd_busy=1 until data_ok.

Source files
------------

// File: rtl/mem_stage_nb_pkg.sv
// mem_stage_nb_pkg: load size encoding, queue entry control fields, load lane extraction
package mem_stage_nb_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} ld_size_e;
  typedef struct packed {
    logic valid;
    logic req;
    logic done;
    logic ld;
    logic uns;
    logic rf_we;
    ld_size_e size;
    logic [2:0] addr_lo;
    logic [4:0] waddr;
  } entry_t;
  // Works on a 64-bit container; loads as wide as the datapath pass through unextended.
  function automatic logic [63:0] load_extract(input logic [63:0] d, input logic [2:0] lo,
                                               input ld_size_e sz, input logic uns, input int bytes);
    logic [3:0] nb = 4'd1 << sz;
    logic [2:0] off = lo & ~(nb[2:0] - 3'd1);
    logic [63:0] sh = d >> {off, 3'b000};
    logic [63:0] m = ~64'd0 >> (7'd64 - {nb, 3'b000});
    logic s = ~uns & |(sh & (m ^ (m >> 1)));
    return (int'(nb) >= bytes) ? sh : (sh & m) | ({64{s}} & ~m);
  endfunction
endpackage

// File: rtl/mem_stage_nb_if.sv
// mem_stage_nb_if: EX/MEM/WB/ID/data-SRAM response signals of the MEM stage
interface mem_stage_nb_if #(
  parameter int DEPTH = 2,
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  parameter int SIDE_W = 64
);
  import mem_stage_nb_pkg::*;
  localparam int LW = $clog2(DATA_W / 8);
  localparam int CW = $clog2(DEPTH + 1);
  logic flush;
  logic ex_valid;
  logic mem_allowin;
  logic ex_req;
  logic ex_ld;
  ld_size_e ex_size;
  logic ex_unsigned;
  logic [LW-1:0] ex_addr_lo;
  logic ex_rf_we;
  logic [4:0] ex_rf_waddr;
  logic [DATA_W-1:0] ex_result;
  logic [PC_W-1:0] ex_pc;
  logic [SIDE_W-1:0] ex_side;
  logic data_ok;
  logic [DATA_W-1:0] rdata;
  logic wb_allowin;
  logic mem_to_wb_valid;
  logic wb_rf_we;
  logic [4:0] wb_rf_waddr;
  logic [DATA_W-1:0] wb_rf_wdata;
  logic [PC_W-1:0] wb_pc;
  logic [SIDE_W-1:0] wb_side;
  logic fwd_we;
  logic [4:0] fwd_waddr;
  logic [DATA_W-1:0] fwd_wdata;
  logic fwd_busy;
  logic [CW-1:0] drain_cnt;
  modport master (
    output flush, ex_valid, ex_req, ex_ld, ex_size, ex_unsigned, ex_addr_lo, ex_rf_we,
           ex_rf_waddr, ex_result, ex_pc, ex_side, data_ok, rdata, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_pc, wb_side,
           fwd_we, fwd_waddr, fwd_wdata, fwd_busy, drain_cnt
  );
  modport slave (
    input  flush, ex_valid, ex_req, ex_ld, ex_size, ex_unsigned, ex_addr_lo, ex_rf_we,
           ex_rf_waddr, ex_result, ex_pc, ex_side, data_ok, rdata, wb_allowin,
    output mem_allowin, mem_to_wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_pc, wb_side,
           fwd_we, fwd_waddr, fwd_wdata, fwd_busy, drain_cnt
  );
endinterface

// File: rtl/mem_stage_nb_load_align.sv
// mem_stage_nb_load_align: selects the addressed lane of a load response and extends it
module mem_stage_nb_load_align
  import mem_stage_nb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [2:0]        addr_lo_i,
  input  ld_size_e          size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] result_o
);
  assign result_o = DATA_W'(load_extract(64'(rdata_i), addr_lo_i, size_i, unsigned_i, DATA_W / 8));
endmodule

// File: rtl/mem_stage_nb.sv
// mem_stage_nb: non-blocking MEM stage, in-order queue with in-order SRAM responses and flush draining
module mem_stage_nb
  import mem_stage_nb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  parameter int SIDE_W = 64
) (
  input logic clk,
  input logic resetn,
  mem_stage_nb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  entry_t ent_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [SIDE_W-1:0] side_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, young, idx, resp_idx;
  logic [CW-1:0] cnt_q, cnt_d, drain_q, drain_d, pend;
  logic deq, enq, stale, found, hit;
  entry_t h, y, ent_d;
  logic [DATA_W-1:0] ld_data;
  mem_stage_nb_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata_i   (bus.rdata),
    .addr_lo_i (ent_q[resp_idx].addr_lo),
    .size_i    (ent_q[resp_idx].size),
    .unsigned_i(ent_q[resp_idx].uns),
    .result_o  (ld_data)
  );
  always_comb begin
    young = tail_q - 1'b1;
    h = ent_q[head_q];
    y = ent_q[young];
    bus.mem_to_wb_valid = h.valid & h.done;
    deq = bus.mem_to_wb_valid & bus.wb_allowin;
    bus.mem_allowin = (cnt_q < CW'(DEPTH)) | deq;
    enq = bus.ex_valid & bus.mem_allowin & ~bus.flush;
    stale = bus.data_ok & (drain_q != '0);
    found = 1'b0;
    resp_idx = head_q;
    pend = '0;
    idx = head_q;
    // Responses are in issue order, so the oldest pending entry from head owns the next beat.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (ent_q[idx].valid & ent_q[idx].req & ~ent_q[idx].done) begin
        pend = pend + 1'b1;
        if (!found) begin
          found = 1'b1;
          resp_idx = idx;
        end
      end
    end
    hit = bus.data_ok & ~stale & found;
    drain_d = drain_q - CW'(stale) + (bus.flush ? pend - CW'(hit) : '0);
    head_d = bus.flush ? '0 : head_q + AW'(deq);
    tail_d = bus.flush ? '0 : tail_q + AW'(enq);
    cnt_d = bus.flush ? '0 : cnt_q + CW'(enq) - CW'(deq);
    ent_d = '{valid: 1'b1, req: bus.ex_req, done: ~bus.ex_req, ld: bus.ex_ld, uns: bus.ex_unsigned,
              rf_we: bus.ex_rf_we, size: bus.ex_size, addr_lo: 3'(bus.ex_addr_lo), waddr: bus.ex_rf_waddr};
    bus.wb_rf_we = h.valid & h.rf_we;
    bus.wb_rf_waddr = h.waddr;
    bus.wb_rf_wdata = data_q[head_q];
    bus.wb_pc = pc_q[head_q];
    bus.wb_side = side_q[head_q];
    bus.fwd_we = y.valid & y.rf_we;
    bus.fwd_waddr = y.waddr;
    bus.fwd_wdata = data_q[young];
    bus.fwd_busy = bus.fwd_we & y.ld & ~y.done;
    bus.drain_cnt = drain_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      drain_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        data_q[i] <= '0;
        pc_q[i] <= '0;
        side_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      if (hit) begin
        ent_q[resp_idx].done <= 1'b1;
        if (ent_q[resp_idx].ld) data_q[resp_idx] <= ld_data;
      end
      if (deq) ent_q[head_q].valid <= 1'b0;
      // When full, tail aliases the retiring head, so the enqueue must follow the dequeue clear.
      if (enq) begin
        ent_q[tail_q] <= ent_d;
        data_q[tail_q] <= bus.ex_result;
        pc_q[tail_q] <= bus.ex_pc;
        side_q[tail_q] <= bus.ex_side;
      end
      if (bus.flush) for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end
  end
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn) bus.data_ok |-> (stale | found));
endmodule

// File: tb/tb_mem_stage_nb.sv
// tb_mem_stage_nb: directed spec scenarios plus random traffic against a queue-based reference model
module tb_mem_stage_nb;
  import mem_stage_nb_pkg::*;
  typedef struct {
    logic [31:0] pc;
    logic [63:0] side;
    logic we;
    logic [4:0] wa;
    logic ld, req, done, uns;
    logic [1:0] sz, lo;
    logic [31:0] data;
  } ment_t;
  logic clk, resetn;
  int ncmp = 0, nerr = 0, drain = 0;
  ment_t mq[$];
  mem_stage_nb_if #(.DEPTH(2), .DATA_W(32), .PC_W(32), .SIDE_W(64)) ifc ();
  mem_stage_nb #(.DEPTH(2), .DATA_W(32), .PC_W(32), .SIDE_W(64)) dut (
    .clk(clk), .resetn(resetn), .bus(ifc.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] sz, input logic [1:0] lo, input logic uns);
    logic [7:0] b;
    logic [15:0] hw;
    if (sz == 2'd0) begin
      b = d[8*int'(lo) +: 8];
      return uns ? {24'd0, b} : {{24{b[7]}}, b};
    end
    if (sz == 2'd1) begin
      hw = d[16*int'(lo[1]) +: 16];
      return uns ? {16'd0, hw} : {{16{hw[15]}}, hw};
    end
    return d;
  endfunction
  function automatic int npend();
    int n = 0;
    foreach (mq[i]) if (mq[i].req && !mq[i].done) n++;
    return n;
  endfunction
  task automatic tick();
    bit have, mv, deq, alw, enq, fwe, busy;
    int k;
    ment_t e;
    @(negedge clk);
    have = mq.size() > 0;
    mv = have && mq[0].done;
    deq = mv && ifc.wb_allowin;
    alw = mq.size() < 2 || deq;
    enq = ifc.ex_valid && alw && !ifc.flush;
    fwe = have && mq[$].we;
    busy = fwe && mq[$].ld && !mq[$].done;
    chk("mem_allowin", ifc.mem_allowin, alw);
    chk("mem_to_wb_valid", ifc.mem_to_wb_valid, mv);
    chk("fwd_we", ifc.fwd_we, fwe);
    chk("fwd_busy", ifc.fwd_busy, busy);
    chk("drain_cnt", ifc.drain_cnt, drain);
    if (mv) begin
      chk("wb_pc", ifc.wb_pc, mq[0].pc);
      chk("wb_side", ifc.wb_side, mq[0].side);
      chk("wb_rf_we", ifc.wb_rf_we, mq[0].we);
      chk("wb_rf_waddr", ifc.wb_rf_waddr, mq[0].wa);
      chk("wb_rf_wdata", ifc.wb_rf_wdata, mq[0].data);
    end
    if (fwe) chk("fwd_waddr", ifc.fwd_waddr, mq[$].wa);
    if (fwe && !busy) chk("fwd_wdata", ifc.fwd_wdata, mq[$].data);
    if (ifc.data_ok) begin
      if (drain > 0) drain--;
      else begin
        k = -1;
        foreach (mq[i]) if (k < 0 && mq[i].req && !mq[i].done) k = i;
        if (k >= 0) begin
          mq[k].done = 1'b1;
          if (mq[k].ld) mq[k].data = ext(ifc.rdata, mq[k].sz, mq[k].lo, mq[k].uns);
        end
      end
    end
    if (ifc.flush) begin
      drain += npend();
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.pc = ifc.ex_pc; e.side = ifc.ex_side; e.we = ifc.ex_rf_we; e.wa = ifc.ex_rf_waddr;
        e.ld = ifc.ex_ld; e.req = ifc.ex_req; e.done = !ifc.ex_req; e.uns = ifc.ex_unsigned;
        e.sz = ifc.ex_size; e.lo = ifc.ex_addr_lo; e.data = ifc.ex_result;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] pc, input logic req, input logic ld, input logic [1:0] sz,
                       input logic uns, input logic [1:0] lo, input logic we, input logic [4:0] wa,
                       input logic [31:0] res);
    ifc.ex_valid = 1'b1; ifc.ex_pc = pc; ifc.ex_req = req; ifc.ex_ld = ld; ifc.ex_size = ld_size_e'(sz);
    ifc.ex_unsigned = uns; ifc.ex_addr_lo = lo; ifc.ex_rf_we = we; ifc.ex_rf_waddr = wa;
    ifc.ex_result = res; ifc.ex_side = {$urandom, $urandom};
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete();
    drain = 0;
  endtask
  initial begin
    ifc.flush = 0; ifc.ex_valid = 0; ifc.data_ok = 0; ifc.rdata = 0; ifc.wb_allowin = 1;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifc.ex_valid = 0;
    do_reset();
    chk("rst_valid", ifc.mem_to_wb_valid, 0);
    chk("rst_allowin", ifc.mem_allowin, 1);
    chk("rst_wb_we", ifc.wb_rf_we, 0);
    chk("rst_wb_data", ifc.wb_rf_wdata, 0);
    chk("rst_wb_pc", ifc.wb_pc, 0);
    chk("rst_fwd_we", ifc.fwd_we, 0);
    chk("rst_fwd_busy", ifc.fwd_busy, 0);
    chk("rst_fwd_data", ifc.fwd_wdata, 0);
    chk("rst_drain", ifc.drain_cnt, 0);
    issue(32'h100, 1, 1, 0, 0, 3, 1, 1, 0); tick(); ifc.ex_valid = 0;
    ifc.data_ok = 1; ifc.rdata = 32'h80FF_0000; tick(); ifc.data_ok = 0;
    chk("ldb_valid", ifc.mem_to_wb_valid, 1);
    chk("ldb_data", ifc.wb_rf_wdata, 32'hFFFF_FF80);
    tick();
    issue(32'h104, 1, 1, 1, 1, 2, 1, 2, 0); tick(); ifc.ex_valid = 0;
    ifc.data_ok = 1; tick(); ifc.data_ok = 0;
    chk("ldhu_data", ifc.wb_rf_wdata, 32'h0000_80FF);
    tick();
    issue(32'h200, 1, 1, 2, 0, 0, 1, 3, 0); tick();
    issue(32'h204, 1, 1, 2, 0, 0, 1, 5, 0); tick();
    issue(32'h208, 0, 0, 2, 0, 0, 1, 6, 0);
    chk("full_allowin", ifc.mem_allowin, 0);
    ifc.ex_valid = 0;
    repeat (2) tick();
    ifc.data_ok = 1; ifc.rdata = $urandom; tick();
    chk("order_a_valid", ifc.mem_to_wb_valid, 1);
    chk("order_a_pc", ifc.wb_pc, 32'h200);
    ifc.rdata = $urandom; tick(); ifc.data_ok = 0;
    chk("order_b_pc", ifc.wb_pc, 32'h204);
    tick();
    issue(32'h300, 1, 1, 2, 0, 0, 1, 3, 0); tick();
    issue(32'h304, 1, 1, 2, 0, 0, 1, 5, 0); tick(); ifc.ex_valid = 0;
    ifc.flush = 1; tick(); ifc.flush = 0;
    chk("flush_drain2", ifc.drain_cnt, 2);
    issue(32'h308, 1, 1, 2, 0, 0, 1, 7, 0); ifc.data_ok = 1; ifc.rdata = $urandom; tick(); ifc.ex_valid = 0;
    tick();
    chk("drained", ifc.drain_cnt, 0);
    chk("stale_not_taken", ifc.mem_to_wb_valid, 0);
    ifc.rdata = 32'h1357_9BDF; tick(); ifc.data_ok = 0;
    chk("post_flush_pc", ifc.wb_pc, 32'h308);
    chk("post_flush_data", ifc.wb_rf_wdata, 32'h1357_9BDF);
    tick();
    issue(32'h400, 1, 1, 2, 0, 0, 1, 3, 0); tick();
    issue(32'h404, 1, 1, 2, 0, 0, 1, 5, 0); tick(); ifc.ex_valid = 0;
    ifc.flush = 1; ifc.data_ok = 1; tick(); ifc.flush = 0; ifc.data_ok = 0;
    chk("flush_hit_drain1", ifc.drain_cnt, 1);
    ifc.data_ok = 1; tick(); ifc.data_ok = 0;
    chk("flush_hit_drain0", ifc.drain_cnt, 0);
    ifc.wb_allowin = 0;
    issue(32'h500, 0, 0, 2, 0, 0, 1, 7, 32'h1234_5678); tick(); ifc.ex_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", ifc.mem_to_wb_valid, 1);
      chk("hold_pc", ifc.wb_pc, 32'h500);
      chk("hold_data", ifc.wb_rf_wdata, 32'h1234_5678);
      chk("hold_fwd_busy", ifc.fwd_busy, 0);
      chk("hold_fwd_data", ifc.fwd_wdata, 32'h1234_5678);
    end
    ifc.wb_allowin = 1; tick();
    chk("hold_released", ifc.mem_to_wb_valid, 0);
    ifc.wb_allowin = 0;
    issue(32'h600, 0, 0, 2, 0, 0, 1, 4, 32'hAAAA); tick();
    issue(32'h604, 1, 1, 2, 0, 0, 1, 4, 0); tick(); ifc.ex_valid = 0;
    chk("fwd_r4_addr", ifc.fwd_waddr, 4);
    chk("fwd_r4_busy", ifc.fwd_busy, 1);
    tick();
    chk("fwd_r4_busy_hold", ifc.fwd_busy, 1);
    ifc.data_ok = 1; ifc.rdata = 32'hDEAD_BEEF; tick(); ifc.data_ok = 0;
    chk("fwd_r4_ready", ifc.fwd_busy, 0);
    chk("fwd_r4_data", ifc.fwd_wdata, 32'hDEAD_BEEF);
    ifc.wb_allowin = 1; tick(); tick();
    chk("fwd_r4_retired", ifc.mem_to_wb_valid, 0);
    issue(32'h700, 1, 1, 2, 0, 0, 1, 9, 0); tick(); ifc.ex_valid = 0;
    ifc.flush = 1; tick(); ifc.flush = 0;
    chk("rst_drain_pre", ifc.drain_cnt, 1);
    do_reset();
    chk("rst_drain_post", ifc.drain_cnt, 0);
    for (int c = 0; c < 3000; c++) begin
      logic req;
      req = 1'($urandom_range(0, 1));
      issue($urandom, req, req & 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      ifc.ex_valid = $urandom_range(0, 3) != 0;
      ifc.flush = drain == 0 && $urandom_range(0, 31) == 0;
      ifc.wb_allowin = $urandom_range(0, 3) != 0;
      ifc.data_ok = (drain + npend()) > 0 && $urandom_range(0, 1) == 1;
      ifc.rdata = $urandom;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
